// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared state encoding and default widths for the divider.
// Revision    : 1.0
// ============================================================================
package div_pkg;

    localparam int C_DW_DEF = 25;
    localparam int C_VW_DEF = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'h0,
        S_CALC = 2'h1,
        S_DONE = 2'h2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/div_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : div_gen_if
// Description : Request/result bundle between a divider client and div_gen.
// Revision    : 1.0
// ============================================================================
interface div_gen_if import div_pkg::*; #(
    parameter int DW = C_DW_DEF,
    parameter int VW = C_VW_DEF
);
    logic          start_p;
    logic          abort_p;
    logic          is_signed;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done_p;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div0;
    logic          ovf;

    modport slave (
        input  start_p, abort_p, is_signed, dividend, divisor,
        output busy, done_p, quotient, remainder, div0, ovf
    );

    modport master (
        output start_p, abort_p, is_signed, dividend, divisor,
        input  busy, done_p, quotient, remainder, div0, ovf
    );
endinterface
`default_nettype wire

// File: rtl/div_gen_step.sv
`default_nettype none
// ============================================================================
// Module      : div_gen_step
// Description : One combinational restoring-division iteration.
// Revision    : 1.0
// ============================================================================
module div_gen_step #(
    parameter int VW = 7
) (
    input  wire logic [VW-1:0] i_rem,
    input  wire logic          i_bit,
    input  wire logic [VW-1:0] i_dvs,
    output logic               o_q,
    output logic [VW-1:0]      o_rem
);
    logic [VW:0]   w_shift;
    logic [VW+1:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    assign w_diff  = {1'b0, w_shift} - {2'b00, i_dvs};
    // Since i_rem < i_dvs, a non-negative trial is below i_dvs, so bit VW
    // can only be set together with the borrow bit.
    assign o_q     = ~|w_diff[VW+1:VW];
    assign o_rem   = o_q ? w_diff[VW-1:0] : w_shift[VW-1:0];
endmodule
`default_nettype wire

// File: rtl/div_gen.sv
`default_nettype none
// ============================================================================
// Module      : div_gen
// Description : Sequential restoring divider, one quotient bit per cycle.
// Revision    : 1.0
// ============================================================================
module div_gen import div_pkg::*; #(
    parameter int DW        = C_DW_DEF,
    parameter int VW        = C_VW_DEF,
    parameter int SIGNED_EN = 1
) (
    input  wire logic clk,
    input  wire logic rstz,
    div_gen_if.slave  bus
);
    localparam int            CW       = $clog2(DW);
    localparam logic [CW-1:0] C_LAST   = CW'(DW - 1);
    localparam logic [DW-1:0] C_DD_MIN = {1'b1, {(DW-1){1'b0}}};

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_num;
    logic [VW-1:0] r_rem, r_dvs;
    logic          r_neg_q, r_neg_r, r_ovf_c, r_div0_c;
    logic [DW-1:0] r_quot;
    logic [VW-1:0] r_remo;
    logic          r_done, r_div0, r_ovf;

    logic          w_sgn, w_dd_neg, w_dv_neg, w_q;
    logic [DW-1:0] w_dd_mag;
    logic [VW-1:0] w_dv_mag, w_rem_nxt;

    assign w_sgn    = (SIGNED_EN != 0) && bus.is_signed;
    assign w_dd_neg = w_sgn && bus.dividend[DW-1];
    assign w_dv_neg = w_sgn && bus.divisor[VW-1];
    assign w_dd_mag = w_dd_neg ? -bus.dividend : bus.dividend;
    assign w_dv_mag = w_dv_neg ? -bus.divisor  : bus.divisor;

    // r_num shifts dividend bits out of its MSB while quotient bits enter at the LSB.
    div_gen_step #(.VW(VW)) u_step (
        .i_rem (r_rem),
        .i_bit (r_num[DW-1]),
        .i_dvs (r_dvs),
        .o_q   (w_q),
        .o_rem (w_rem_nxt)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start_p) w_next = (bus.divisor == '0) ? S_DONE : S_CALC;
            S_CALC:  if (bus.abort_p) w_next = S_IDLE;
                     else if (r_cnt == C_LAST) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_cnt    <= '0;
            r_num    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_ovf_c  <= 1'b0;
            r_div0_c <= 1'b0;
            r_quot   <= '0;
            r_remo   <= '0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start_p) begin
                    r_cnt    <= '0;
                    r_num    <= w_dd_mag;
                    r_rem    <= '0;
                    r_dvs    <= w_dv_mag;
                    r_neg_q  <= w_dd_neg ^ w_dv_neg;
                    r_neg_r  <= w_dd_neg;
                    r_ovf_c  <= w_sgn && (bus.dividend == C_DD_MIN) && (bus.divisor == '1);
                    r_div0_c <= (bus.divisor == '0);
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CW'(1);
                    r_num <= {r_num[DW-2:0], w_q};
                    r_rem <= w_rem_nxt;
                end
                S_DONE: if (!bus.abort_p) begin
                    if (r_div0_c) begin
                        r_quot <= '1;
                        r_remo <= '0;
                        r_div0 <= 1'b1;
                        r_ovf  <= 1'b0;
                    end else begin
                        r_quot <= r_neg_q ? -r_num : r_num;
                        r_remo <= r_neg_r ? -r_rem : r_rem;
                        r_div0 <= 1'b0;
                        r_ovf  <= r_ovf_c;
                    end
                end
                default: ;
            endcase
            r_done <= (r_state == S_DONE) && !bus.abort_p;
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done_p    = r_done;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_remo;
    assign bus.div0      = r_div0;
    assign bus.ovf       = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_div_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_gen
// Description : Self-checking bench for div_gen (vector table + random model).
// Revision    : 1.0
// ============================================================================
module tb_div_gen;
    import div_pkg::*;

    localparam int DW = 25;
    localparam int VW = 7;

    logic clk  = 1'b0;
    logic rstz = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    div_gen_if #(.DW(DW), .VW(VW)) bus ();

    div_gen #(.DW(DW), .VW(VW), .SIGNED_EN(1)) dut (
        .clk  (clk),
        .rstz (rstz),
        .bus  (bus)
    );

    typedef struct {
        logic          sgn;
        logic [DW-1:0] dd;
        logic [VW-1:0] dv;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          z;
        logic          o;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, C-style truncation for signed operands.
    function automatic void model(input logic sgn, input logic [DW-1:0] dd, input logic [VW-1:0] dv,
                                  output logic [DW-1:0] q, output logic [VW-1:0] r,
                                  output logic z, output logic o);
        longint a, b;
        z = (dv == '0);
        o = 1'b0;
        if (z) begin
            q = '1;
            r = '0;
            return;
        end
        if (sgn) begin
            a = longint'($signed(dd));
            b = longint'($signed(dv));
        end else begin
            a = longint'(dd);
            b = longint'(dv);
        end
        q = DW'(a / b);
        r = VW'(a % b);
        o = sgn && (a == -(longint'(1) << (DW - 1))) && (b == -1);
    endfunction

    // Starts immediately at the current time (#1 after an edge); the next edge is the start edge.
    // lat counts edges after the start edge up to the one at which done_p rises.
    task automatic run_op(input logic sgn, input logic [DW-1:0] dd, input logic [VW-1:0] dv,
                          input bit with_abort, input int inject_at, output int lat);
        bit busy_ok = 1'b1;
        lat = -1;
        bus.start_p   = 1'b1;
        bus.abort_p   = with_abort;
        bus.is_signed = sgn;
        bus.dividend  = dd;
        bus.divisor   = dv;
        @(posedge clk); #1;
        bus.start_p   = 1'b0;
        bus.abort_p   = 1'b0;
        bus.is_signed = 1'($urandom);
        bus.dividend  = DW'($urandom);
        bus.divisor   = VW'($urandom);
        if (!bus.busy) busy_ok = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            bus.start_p = (n == inject_at);
            @(posedge clk); #1;
            if (bus.done_p) begin
                lat = n;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
        bus.start_p = 1'b0;
        chk("busy_during_op", 32'(busy_ok), 32'd1);
        chk("busy_after_done", 32'(bus.busy), 32'd0);
    endtask

    task automatic run_cmp(input string tag, input logic sgn, input logic [DW-1:0] dd,
                           input logic [VW-1:0] dv, input logic [DW-1:0] eq, input logic [VW-1:0] er,
                           input logic ez, input logic eo, input bit with_abort, input int inject_at);
        int lat;
        run_op(sgn, dd, dv, with_abort, inject_at, lat);
        chk({tag, "_latency"}, 32'(lat), (dv == '0) ? 32'd1 : 32'(DW + 1));
        chk({tag, "_quotient"}, 32'(bus.quotient), 32'(eq));
        chk({tag, "_remainder"}, 32'(bus.remainder), 32'(er));
        chk({tag, "_div0"}, 32'(bus.div0), 32'(ez));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
    endtask

    task automatic count_done(input int cycles, output int hits);
        hits = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk); #1;
            if (bus.done_p) hits++;
        end
    endtask

    initial begin
        int            hits;
        logic          rs, rz, ro;
        logic [DW-1:0] rdd, rq;
        logic [VW-1:0] rdv, rr;

        tbl[0] = '{1'b0, 25'd1000,     7'd7,    25'd142,       7'd6,    1'b0, 1'b0};
        tbl[1] = '{1'b1, 25'h1FFFF9C,  7'd7,    25'h1FFFFF2,   7'h7E,   1'b0, 1'b0};
        tbl[2] = '{1'b1, 25'd100,      7'h79,   25'h1FFFFF2,   7'd2,    1'b0, 1'b0};
        tbl[3] = '{1'b0, 25'd55,       7'd0,    25'h1FFFFFF,   7'd0,    1'b1, 1'b0};
        tbl[4] = '{1'b1, 25'h1000000,  7'h7F,   25'h1000000,   7'd0,    1'b0, 1'b1};
        tbl[5] = '{1'b0, 25'd33,       7'd5,    25'd6,         7'd3,    1'b0, 1'b0};

        bus.start_p = 1'b0; bus.abort_p = 1'b0; bus.is_signed = 1'b0;
        bus.dividend = '0;  bus.divisor = '0;

        #12;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done_p), 32'd0);
        chk("reset_quotient", 32'(bus.quotient), 32'd0);
        chk("reset_remainder", 32'(bus.remainder), 32'd0);
        chk("reset_flags", {30'd0, bus.div0, bus.ovf}, 32'd0);
        @(posedge clk); #1;
        rstz = 1'b1;
        @(posedge clk); #1;

        // Table entries run back to back: each start coincides with the previous done_p.
        for (int i = 0; i < 6; i++)
            run_cmp($sformatf("vec%0d", i), tbl[i].sgn, tbl[i].dd, tbl[i].dv,
                    tbl[i].q, tbl[i].r, tbl[i].z, tbl[i].o, 1'b0, 0);
        @(posedge clk); #1;
        chk("done_pulse_width", 32'(bus.done_p), 32'd0);

        // Abort during CALC after a known result of 1000/7.
        run_cmp("pre_abort", 1'b0, 25'd1000, 7'd7, 25'd142, 7'd6, 1'b0, 1'b0, 1'b0, 0);
        bus.start_p = 1'b1; bus.is_signed = 1'b0; bus.dividend = 25'd500; bus.divisor = 7'd3;
        @(posedge clk); #1;
        bus.start_p = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
        end
        bus.abort_p = 1'b1;
        @(posedge clk); #1;
        bus.abort_p = 1'b0;
        chk("abort_calc_busy", 32'(bus.busy), 32'd0);
        count_done(40, hits);
        chk("abort_calc_no_done", 32'(hits), 32'd0);
        chk("abort_calc_held_q", 32'(bus.quotient), 32'd142);
        chk("abort_calc_held_r", 32'(bus.remainder), 32'd6);
        run_cmp("after_abort", 1'b0, 25'd33, 7'd5, 25'd6, 7'd3, 1'b0, 1'b0, 1'b0, 0);

        // Abort while in DONE (zero divisor reaches DONE right after the start edge).
        bus.start_p = 1'b1; bus.is_signed = 1'b0; bus.dividend = 25'd55; bus.divisor = 7'd0;
        @(posedge clk); #1;
        bus.start_p = 1'b0;
        bus.abort_p = 1'b1;
        @(posedge clk); #1;
        bus.abort_p = 1'b0;
        chk("abort_done_no_pulse", 32'(bus.done_p), 32'd0);
        chk("abort_done_busy", 32'(bus.busy), 32'd0);
        count_done(5, hits);
        chk("abort_done_no_done", 32'(hits), 32'd0);
        chk("abort_done_held_q", 32'(bus.quotient), 32'd6);
        chk("abort_done_held_div0", 32'(bus.div0), 32'd0);

        // start_p with abort_p in IDLE starts; a start mid-operation is ignored.
        run_cmp("start_with_abort", 1'b1, 25'h1FFFF9C, 7'd7, 25'h1FFFFF2, 7'h7E, 1'b0, 1'b0, 1'b1, 0);
        run_cmp("restart_ignored", 1'b0, 25'd1000, 7'd7, 25'd142, 7'd6, 1'b0, 1'b0, 1'b0, 5);

        // Reset mid-CALC.
        bus.start_p = 1'b1; bus.is_signed = 1'b0; bus.dividend = 25'd777; bus.divisor = 7'd9;
        @(posedge clk); #1;
        bus.start_p = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
        end
        #2 rstz = 1'b0;
        #1;
        chk("midreset_busy", 32'(bus.busy), 32'd0);
        chk("midreset_quotient", 32'(bus.quotient), 32'd0);
        chk("midreset_remainder", 32'(bus.remainder), 32'd0);
        chk("midreset_flags", {29'd0, bus.done_p, bus.div0, bus.ovf}, 32'd0);
        @(posedge clk); #1;
        rstz = 1'b1;
        count_done(40, hits);
        chk("midreset_no_done", 32'(hits), 32'd0);

        for (int i = 0; i < 150; i++) begin
            int sel;
            sel = int'($urandom_range(0, 15));
            rs  = 1'($urandom);
            rdd = DW'($urandom);
            rdv = VW'($urandom);
            if (sel == 0) rdv = '0;
            if (sel == 1) begin
                rs  = 1'b1;
                rdd = {1'b1, {(DW-1){1'b0}}};
                rdv = '1;
            end
            model(rs, rdd, rdv, rq, rr, rz, ro);
            run_cmp($sformatf("rnd%0d", i), rs, rdd, rdv, rq, rr, rz, ro, 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
